// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receives the multiplexed two-bank 7-segment bus and rebuilds a 4-digit frame
module seg_scan_capture #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK_in,
    input  logic        RST_in,
    input  logic [13:0] Disp_in,
    input  logic        Disp_on_in,
    input  logic        Frame_ready_in,
    output logic        Frame_valid_out,
    output logic [15:0] Dig_out,
    output logic [3:0]  Blank_out,
    output logic [3:0]  Minus_out,
    output logic [3:0]  Bad_out,
    output logic        Miss_out,
    output logic        Stall_out,
    output logic        Overrun_out
);

    localparam int              TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STB = 8'(STABLE_CYCLES);
    localparam logic [TW-1:0]   TMO = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {SYNC, SETTLE0, HOLD0, SETTLE1, HOLD1} state_t;

    // Decoded digit packed as {bad, minus, blank, nibble}; non-hex classes carry nibble 0
    function automatic logic [6:0] dec(input logic [6:0] p);
        case (p)
            7'h7E: dec = 7'h00;
            7'h30: dec = 7'h01;
            7'h6D: dec = 7'h02;
            7'h79: dec = 7'h03;
            7'h33: dec = 7'h04;
            7'h5B: dec = 7'h05;
            7'h5F: dec = 7'h06;
            7'h70: dec = 7'h07;
            7'h7F: dec = 7'h08;
            7'h7B: dec = 7'h09;
            7'h77: dec = 7'h0A;
            7'h1F: dec = 7'h0B;
            7'h4E: dec = 7'h0C;
            7'h3D: dec = 7'h0D;
            7'h4F: dec = 7'h0E;
            7'h47: dec = 7'h0F;
            7'h00: dec = 7'b0010000;
            7'h01: dec = 7'b0100000;
            default: dec = 7'b1000000;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0][14:0] sync_q, sync_d;
    logic [13:0]   prev_d_q, prev_d_d;
    logic          prev_on_q, prev_on_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    state_t        state_q, state_d;
    logic [13:0]   b0_q, b0_d;
    logic          valid_q, valid_d;
    logic [15:0]   dig_q, dig_d;
    logic [3:0]    blank_q, blank_d, minus_q, minus_d, bad_q, bad_d;
    logic          miss_q, miss_d, ovr_q, ovr_d;
    logic [13:0]   seg_s;
    logic          on_s, edge_w, stall, cap, done, hs, load;
    logic [6:0]    dec_hi, dec_lo;

    // Synchronizer shift, bank-select edge detect, stability and timeout counters
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], Disp_on_in, Disp_in};
        seg_s     = sync_q[SYNC_STAGES-1][13:0];
        on_s      = sync_q[SYNC_STAGES-1][14];
        edge_w    = on_s != prev_on_q;
        prev_d_d  = seg_s;
        prev_on_d = on_s;
        cnt_d     = (edge_w || seg_s != prev_d_q) ? 8'd0 : (cnt_q == STB) ? cnt_q : cnt_q + 8'd1;
        tmo_d     = edge_w ? '0 : (tmo_q == TMO) ? tmo_q : tmo_q + TW'(1);
        stall     = tmo_q == TMO;
        dec_hi    = dec(seg_s[13:7]);
        dec_lo    = dec(seg_s[6:0]);
    end

    // Bank sequencing: capture each bank once it has settled, abort on an early edge, drop to SYNC on stall
    always_comb begin
        state_d = state_q;
        miss_d  = 1'b0;
        cap     = 1'b0;
        case (state_q)
            SYNC:    if (edge_w && !on_s) state_d = SETTLE0;
            SETTLE0,
            SETTLE1: begin
                if (edge_w) begin
                    miss_d  = 1'b1;
                    state_d = SYNC;
                end else if (cnt_d == STB) begin
                    cap     = 1'b1;
                    state_d = (state_q == SETTLE0) ? HOLD0 : HOLD1;
                end
            end
            HOLD0:   if (edge_w && on_s) state_d = SETTLE1;
            HOLD1:   if (edge_w && !on_s) state_d = SETTLE0;
            default: state_d = SYNC;
        endcase
        if (stall) begin
            state_d = SYNC;
            cap     = 1'b0;
        end
        done = cap && state_q == SETTLE1;
        b0_d = (cap && state_q == SETTLE0) ? {dec_hi, dec_lo} : b0_q;
    end

    // Frame presentation: load on completion when the slot is free or being handed off, else flag overrun
    always_comb begin
        hs      = valid_q && Frame_ready_in;
        load    = done && (!valid_q || hs);
        valid_d = load || (valid_q && !hs);
        dig_d   = load ? {dec_hi[3:0], dec_lo[3:0], b0_q[10:7], b0_q[3:0]} : dig_q;
        blank_d = load ? {dec_hi[4], dec_lo[4], b0_q[11], b0_q[4]} : blank_q;
        minus_d = load ? {dec_hi[5], dec_lo[5], b0_q[12], b0_q[5]} : minus_q;
        bad_d   = load ? {dec_hi[6], dec_lo[6], b0_q[13], b0_q[6]} : bad_q;
        ovr_d   = ovr_q || (done && valid_q && !Frame_ready_in);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            sync_q    <= '0;
            prev_d_q  <= '0;
            prev_on_q <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            state_q   <= SYNC;
            b0_q      <= '0;
            valid_q   <= 1'b0;
            dig_q     <= '0;
            blank_q   <= '0;
            minus_q   <= '0;
            bad_q     <= '0;
            miss_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_d_q  <= prev_d_d;
            prev_on_q <= prev_on_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            state_q   <= state_d;
            b0_q      <= b0_d;
            valid_q   <= valid_d;
            dig_q     <= dig_d;
            blank_q   <= blank_d;
            minus_q   <= minus_d;
            bad_q     <= bad_d;
            miss_q    <= miss_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Frame_valid_out = valid_q;
    assign Dig_out         = dig_q;
    assign Blank_out       = blank_q;
    assign Minus_out       = minus_q;
    assign Bad_out         = bad_q;
    assign Miss_out        = miss_q;
    assign Stall_out       = stall;
    assign Overrun_out     = ovr_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed and randomized checks of the scan-bus receiver against a table-driven frame model
module tb_seg_scan_capture;

    logic        CLK_in = 1'b0;
    logic        RST_in;
    logic [13:0] Disp_in;
    logic        Disp_on_in;
    logic        Frame_ready_in;
    logic        Frame_valid_out;
    logic [15:0] Dig_out;
    logic [3:0]  Blank_out, Minus_out, Bad_out;
    logic        Miss_out, Stall_out, Overrun_out;

    int checks   = 0;
    int failures = 0;
    int miss_cnt = 0;
    logic [27:0] obs_q[$];
    logic [27:0] exp_q[$];

    logic [6:0] hex_pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg_scan_capture dut (
        .CLK_in(CLK_in), .RST_in(RST_in), .Disp_in(Disp_in), .Disp_on_in(Disp_on_in),
        .Frame_ready_in(Frame_ready_in), .Frame_valid_out(Frame_valid_out), .Dig_out(Dig_out),
        .Blank_out(Blank_out), .Minus_out(Minus_out), .Bad_out(Bad_out), .Miss_out(Miss_out),
        .Stall_out(Stall_out), .Overrun_out(Overrun_out)
    );

    always #5 CLK_in = ~CLK_in;

    // Record every completed handshake and every miss pulse
    always @(posedge CLK_in) begin
        if (Frame_valid_out && Frame_ready_in) obs_q.push_back({Dig_out, Blank_out, Minus_out, Bad_out});
        if (Miss_out) miss_cnt++;
    end

    // Reference frame: p = {b1hi, b1lo, b0hi, b0lo}, result = {dig, blank, minus, bad}
    function automatic logic [27:0] model(input logic [27:0] p);
        logic [15:0] d;
        logic [3:0]  bl, mi, bd;
        logic [6:0]  pat;
        d = '0; bl = '0; mi = '0; bd = '0;
        for (int k = 0; k < 4; k++) begin
            pat   = p[7*k +: 7];
            bl[k] = pat == 7'h00;
            mi[k] = pat == 7'h01;
            bd[k] = !(bl[k] || mi[k]);
            for (int j = 0; j < 16; j++)
                if (hex_pat[j] == pat) begin
                    d[4*k +: 4] = 4'(j);
                    bd[k] = 1'b0;
                end
        end
        return {d, bl, mi, bd};
    endfunction

    function automatic logic [6:0] rnd_pat();
        int c;
        c = $urandom_range(0, 18);
        return c < 16 ? hex_pat[c] : c == 16 ? 7'h00 : c == 17 ? 7'h01 : 7'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drive(input logic on, input logic [6:0] hi, input logic [6:0] lo, input int n);
        Disp_on_in = on;
        Disp_in    = {hi, lo};
        repeat (n) @(negedge CLK_in);
    endtask

    task automatic frame(input logic [27:0] p, input int h0, input int h1);
        drive(1'b0, p[13:7], p[6:0], h0);
        drive(1'b1, p[27:21], p[20:14], h1);
    endtask

    task automatic chk_obs(input string tag, input logic [27:0] e);
        chk({tag, "_count"}, obs_q.size(), 1);
        if (obs_q.size() != 0) chk(tag, obs_q[0], e);
    endtask

    initial begin
        logic [27:0] p, a, b;
        int n;
        Disp_in = 14'h3FFF; Disp_on_in = 1'b1; Frame_ready_in = 1'b1; RST_in = 1'b1;
        repeat (2) @(negedge CLK_in);
        chk("rst_valid", Frame_valid_out, 0);
        chk("rst_dig", Dig_out, 0);
        chk("rst_blank", Blank_out, 0);
        chk("rst_minus", Minus_out, 0);
        chk("rst_bad", Bad_out, 0);
        chk("rst_miss", Miss_out, 0);
        chk("rst_stall", Stall_out, 0);
        chk("rst_ovr", Overrun_out, 0);
        RST_in = 1'b0;
        repeat (4) @(negedge CLK_in);

        // Nominal frame with latency measured from the bank1 pin change
        drive(1'b0, 7'h30, 7'h6D, 20);
        Disp_on_in = 1'b1; Disp_in = {7'h01, 7'h4F};
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK_in); n++;
            @(negedge CLK_in);
            if (Frame_valid_out) break;
        end
        chk("nom_latency", n, 7);
        chk("nom_dig", Dig_out, 16'h0E12);
        chk("nom_minus", Minus_out, 4'b1000);
        chk("nom_blank", Blank_out, 0);
        chk("nom_bad", Bad_out, 0);
        drive(1'b1, 7'h01, 7'h4F, 20 - n);

        // Glitching bank0 then a toggle: one miss, no frame; then a clean frame
        obs_q.delete(); miss_cnt = 0;
        for (int i = 0; i < 10; i++) drive(1'b0, 7'(i), 7'(3 * i + 1), 1);
        drive(1'b1, 7'h30, 7'h30, 12);
        chk("glitch_miss", miss_cnt, 1);
        chk("glitch_noframe", obs_q.size(), 0);
        p = {7'h00, 7'h7F, 7'h7E, 7'h5B};
        frame(p, 12, 12);
        chk_obs("clean", model(p));
        chk("clean_miss", miss_cnt, 1);

        // Invalid pattern on bank0 high digit
        obs_q.delete();
        p = {7'h47, 7'h1F, 7'h55, 7'h30};
        frame(p, 12, 12);
        chk_obs("inval", model(p));
        chk("inval_bad1", Bad_out[1], 1);
        chk("inval_dig74", Dig_out[7:4], 0);

        // Backpressure across two frames, then a one-cycle ready pulse
        obs_q.delete();
        Frame_ready_in = 1'b0;
        a = {7'h6D, 7'h79, 7'h33, 7'h5F};
        b = {7'h70, 7'h7B, 7'h77, 7'h3D};
        frame(a, 12, 12);
        chk("bp_valid_a", Frame_valid_out, 1);
        chk("bp_dig_a", Dig_out, model(a) >> 12);
        frame(b, 12, 12);
        chk("bp_held", {Dig_out, Blank_out, Minus_out, Bad_out}, model(a));
        chk("bp_ovr", Overrun_out, 1);
        chk("bp_valid_b", Frame_valid_out, 1);
        Frame_ready_in = 1'b1;
        @(negedge CLK_in);
        Frame_ready_in = 1'b0;
        chk("bp_drop", Frame_valid_out, 0);
        chk_obs("bp_hs", model(a));
        Frame_ready_in = 1'b1;

        // Stall: bank select frozen long enough to time out, then recovery through SYNC
        drive(1'b0, 7'h7E, 7'h7E, 12);
        Disp_on_in = 1'b1; Disp_in = {7'h30, 7'h30};
        repeat (1026) @(negedge CLK_in);
        chk("stall_before", Stall_out, 0);
        @(negedge CLK_in);
        chk("stall_at", Stall_out, 1);
        repeat (73) @(negedge CLK_in);
        chk("stall_hold", Stall_out, 1);
        Disp_on_in = 1'b0;
        repeat (2) @(negedge CLK_in);
        chk("stall_edge", Stall_out, 1);
        @(negedge CLK_in);
        chk("stall_clear", Stall_out, 0);
        obs_q.delete();
        drive(1'b0, 7'h30, 7'h30, 9);
        drive(1'b1, 7'h30, 7'h30, 12);
        p = {7'h4E, 7'h01, 7'h00, 7'h79};
        frame(p, 12, 12);
        chk_obs("stall_resume", model(p));

        // Randomized frames with random hold times against the reference model
        obs_q.delete(); exp_q.delete(); miss_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            p = {rnd_pat(), rnd_pat(), rnd_pat(), rnd_pat()};
            exp_q.push_back(model(p));
            frame(p, $urandom_range(8, 20), $urandom_range(8, 20));
        end
        chk("rnd_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk($sformatf("rnd_%0d", i), obs_q[i], exp_q[i]);
        chk("rnd_miss", miss_cnt, 0);

        // Reset while bank1 settles discards the partial frame
        obs_q.delete();
        drive(1'b0, 7'h7F, 7'h7F, 12);
        drive(1'b1, 7'h5B, 7'h5B, 3);
        RST_in = 1'b1;
        @(negedge CLK_in);
        RST_in = 1'b0;
        repeat (12) @(negedge CLK_in);
        chk("mid_rst_noframe", obs_q.size(), 0);
        chk("mid_rst_valid", Frame_valid_out, 0);
        chk("mid_rst_dig", Dig_out, 0);
        chk("mid_rst_ovr", Overrun_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side decoder for the multiplexed 7-segment display bus driven by the ALU/decoder project: 14 segment lines (two digits) plus one bank-select line that alternates between two digit banks.
- Synchronizes the bus, waits for each bank to settle, and decodes the segment patterns back to hex nibbles with per-digit class flags.
- Presents one 4-digit frame through a valid/ready handshake.
- Serves as a board-side/second-chip receiver and as a self-check monitor in the project testbench.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every input line (min 2).
- STABLE_CYCLES, 4, consecutive unchanged synced samples required before a bank is captured (1..255).
- TIMEOUT_CYCLES, 1024, cycles without a bank-select edge before stall is declared.

Ports:
- CLK_in  in  1  system clock.
- RST_in  in  1  synchronous reset, active-high.
- Disp_in  in  14  segment bus; [13:7] high digit, [6:0] low digit; each digit a..g = bit6..bit0, active-high.
- Disp_on_in  in  1  bank select; 0 = bank0, 1 = bank1.
- Frame_ready_in  in  1  consumer ready.
- Frame_valid_out  out  1  frame available.
- Dig_out  out  16  [15:12] bank1 hi, [11:8] bank1 lo, [7:4] bank0 hi, [3:0] bank0 lo.
- Blank_out  out  4  per-digit blank flag (same digit order as Dig_out nibbles, bit3 = [15:12]).
- Minus_out  out  4  per-digit minus-sign flag.
- Bad_out  out  4  per-digit invalid-pattern flag.
- Miss_out  out  1  one-cycle pulse: bank aborted before settling.
- Stall_out  out  1  bank select idle for at least TIMEOUT_CYCLES.
- Overrun_out  out  1  sticky: completed frame dropped.

Behaviour:
- Reset (RST_in high at a clock edge) sets:
  - all outputs to 0;
  - synchronizers to 0;
  - state to SYNC;
  - stability and timeout counters to 0.
- Reset mid-frame discards the partial frame and any pending frame.
- All logic uses synced copies: sD (14 bits) and sOn. Edge means sOn differs from its previous-cycle value.
- Decode table (7-bit hex pattern, then class):
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F;
  - 00 = blank;
  - 01 = minus;
  - anything else = bad.
  - Non-hex classes report nibble 0.
- Stability counter:
  - cleared on an edge;
  - otherwise increments when sD equals the previous sD, and clears when it differs;
  - saturates at STABLE_CYCLES.
- States:
  - SYNC: wait for a falling edge of sOn, then go to SETTLE0.
  - SETTLE0: when the counter reaches STABLE_CYCLES, latch the decoded sD into bank0 holding registers and go to HOLD0.
    - Any edge before capture: pulse Miss_out, go to SYNC.
  - HOLD0: ignore sD. On a rising edge go to SETTLE1. A falling edge cannot occur here.
  - SETTLE1: same capture and miss rules as SETTLE0, capturing into bank1.
    - On capture, the frame is complete; go to HOLD1.
  - HOLD1: on a falling edge go to SETTLE0.
- Latency: with sD constant from edge cycle E, capture happens at clock edge E+STABLE_CYCLES. Pin-to-sync delay adds SYNC_STAGES cycles.
- Frame output:
  - On frame completion with Frame_valid_out low: load Dig_out, Blank_out, Minus_out and Bad_out from both banks; Frame_valid_out is high from the next cycle.
  - Outputs are held stable while Frame_valid_out is high.
  - Handshake completes on a clock edge with valid and ready both high. Frame_valid_out then drops the next cycle.
  - If a new frame completes on the same edge as a handshake, the new frame loads and valid stays high.
  - If a frame completes while valid is high and ready is low: the frame is dropped, Overrun_out is set (cleared only by reset), and the FSM continues normally.
- Timeout counter:
  - cleared on any edge and saturates at TIMEOUT_CYCLES;
  - while it is at TIMEOUT_CYCLES, Stall_out is high and the state is forced to SYNC;
  - Stall_out clears on the cycle after the next edge.
- A miss and a stall in the same cycle: both flags assert and the state goes to SYNC.

Test Plan:
- Reset then idle: RST_in high for 2 cycles with Disp_in=3FFF and Disp_on_in=1 -> all outputs 0, no frame.
- Nominal frame:
  - Stimulus: bank0 Disp_in={30,6D} (digits 1,2) and bank1 Disp_in={01,4F} (minus, E), each held 20 cycles, alternating 0,1,0.
  - Required: Frame_valid_out rises 2+4+1 cycles after the bank1 pin change, Dig_out=0x0E12, Minus_out=0b1000, Blank_out=0, Bad_out=0.
- Glitch/miss:
  - Stimulus: bank0 with sD changing every cycle for 10 cycles, then a toggle to bank1.
  - Required: Miss_out pulses once, no frame; the next clean 0/1 cycle yields a valid frame.
- Invalid pattern: bank0 hi = 7-bit 0x55 -> Bad_out[1]=1 and Dig_out[7:4]=0.
- Backpressure: hold Frame_ready_in=0 across two frames -> first frame held unchanged, Overrun_out=1; raise ready for 1 cycle -> valid drops the next cycle.
- Stall: freeze Disp_on_in for 1100 cycles -> Stall_out high from timeout; the next toggle clears it and capture resumes from SYNC.
